slave_transmit: RTL and testbench



---
 rtl/slave_transmit_if.sv | 22 ++
 rtl/slave_transmit.sv | 136 +++++++++++++
 tb/tb_slave_transmit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_transmit_if.sv
// slave_transmit_if: nonce strobe input plus serial line and status outputs of the nonce transmitter.
// Latency: n/a (signal bundle only).
// Backpressure: none; overflow/fifo_full report words that could not be held.
// Signals: nonce[31:0], new_nonce (toward transmitter); TxD, busy, fifo_full, overflow (from transmitter).
interface slave_transmit_if;
    logic [31:0] nonce;
    logic        new_nonce;
    logic        TxD;
    logic        busy;
    logic        fifo_full;
    logic        overflow;

    modport master (
        output nonce, new_nonce,
        input  TxD, busy, fifo_full, overflow
    );

    modport slave (
        input  nonce, new_nonce,
        output TxD, busy, fifo_full, overflow
    );
endinterface

// File: rtl/slave_transmit.sv
// slave_transmit: buffers 32-bit nonces and sends each as four 8N1 UART bytes, MSB byte first.
// Latency: strobe at edge k -> popped at k+1 -> start bit on TxD after edge k+2; word = 40*BAUD_DIV cycles.
// Backpressure: none; a strobe while FIFO_DEPTH words are held is dropped and sets sticky overflow.
// Ports: clk, reset (sync, active high); bus.slave carries nonce/new_nonce in, TxD/busy/fifo_full/overflow out.
module slave_transmit #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    slave_transmit_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   hold;
    logic [7:0]    cur_byte;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          baud_end;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_nxt;
    logic          word_done;
    logic          idle_nxt;

    // The byte on the wire is always the top byte; the holding register shifts up between bytes.
    assign cur_byte = hold[31:24];

    always_comb begin
        baud_end  = (baud_cnt == BAUD_LAST);
        // Fullness uses the registered count, so a same-cycle pop never makes room for a push.
        push      = bus.new_nonce && (count != FULL_CNT);
        pop       = (state == IDLE) && (count != '0);
        count_nxt = count + CW'(push) - CW'(pop);
        word_done = (state == STOP) && baud_end && (byte_idx == 2'd3);
        // State after this edge is IDLE: staying idle with nothing to pop, or finishing the last stop bit.
        idle_nxt  = ((state == IDLE) && !pop) || word_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            byte_idx      <= '0;
            hold          <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.TxD       <= 1'b1;
            bus.busy      <= 1'b0;
            bus.fifo_full <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.nonce;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (bus.new_nonce && !push) begin
                bus.overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count         <= count_nxt;
            // Status flags reflect the FIFO and state as they will be after this edge.
            bus.busy      <= !idle_nxt || (count_nxt != '0);
            bus.fifo_full <= (count_nxt == FULL_CNT);

            // TxD is computed from the current state, so the line lags the state register by one cycle.
            case (state)
                IDLE: begin
                    bus.TxD <= 1'b1;
                    if (pop) begin
                        hold     <= mem[rd_ptr];
                        byte_idx <= '0;
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    bus.TxD <= 1'b0;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    bus.TxD <= cur_byte[bit_idx];
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    bus.TxD <= 1'b1;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (byte_idx == 2'd3) begin
                            state <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            hold     <= {hold[23:0], 8'h00};
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_slave_transmit.sv
// tb_slave_transmit: drives nonce strobes into slave_transmit and decodes TxD back into words.
// Latency: expected start-bit cycle per word comes from a word-level timeline model (pop = max(push+1, prev pop+40*B+1)).
// Backpressure: model predicts drops from FIFO occupancy at each strobe; dropped words never enter the scoreboard.
// Ports: none; instantiates slave_transmit_if and slave_transmit with BAUD_DIV=4, FIFO_DEPTH=4.
module tb_slave_transmit;
    localparam int B        = 4;
    localparam int D        = 4;
    localparam int WORD_CYC = 40 * B;

    typedef struct {
        logic [31:0] w;
        int          st;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    slave_transmit_if bus();

    slave_transmit #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Word-level model: edge each word was pushed, edge it leaves the FIFO, and its value.
    int          m_push[$];
    int          m_pop[$];
    logic [31:0] m_val[$];
    int          ovf_at = -1;
    exp_t        exp_q[$];
    bit          chk_en    = 1'b0;
    bit          mon_abort = 1'b0;
    bit          full_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic model_push(input logic [31:0] v, input int k);
        int occ;
        int pop;
        occ = 0;
        foreach (m_push[i]) if (m_push[i] < k && m_pop[i] >= k) occ++;
        if (occ >= D) begin
            if (ovf_at < 0) ovf_at = k;
        end else begin
            pop = k + 1;
            if (m_pop.size() > 0 && m_pop[$] + WORD_CYC + 1 > pop) pop = m_pop[$] + WORD_CYC + 1;
            m_push.push_back(k);
            m_pop.push_back(pop);
            m_val.push_back(v);
            exp_q.push_back('{w: v, st: pop + 1});
        end
    endtask

    // Called at a negedge; the strobe is sampled at the following posedge.
    task automatic strobe(input logic [31:0] v);
        bus.new_nonce = 1'b1;
        bus.nonce     = v;
        model_push(v, cyc + 1);
        @(negedge clk);
        bus.new_nonce = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        m_push.delete();
        m_pop.delete();
        m_val.delete();
        exp_q.delete();
        ovf_at    = -1;
        mon_abort = 1'b1;
        chk_en    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 8 * WORD_CYC * D;
        while ((exp_q.size() != 0 || bus.busy !== 1'b0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout cycle %0d: pending %0d busy %b", cyc, exp_q.size(), bus.busy);
        end
        repeat (2 * B) @(negedge clk);
    endtask

    // Cycle-by-cycle expectations of every output derived from the word timeline.
    always @(negedge clk) begin
        if (chk_en) begin
            int   occ, t, b, p;
            bit   act;
            logic txe;
            occ = 0;
            act = 1'b0;
            txe = 1'b1;
            foreach (m_push[i]) begin
                if (m_push[i] <= cyc && m_pop[i] > cyc) occ++;
                if (m_pop[i] <= cyc && cyc < m_pop[i] + WORD_CYC) act = 1'b1;
                if (cyc >= m_pop[i] + 1 && cyc < m_pop[i] + 1 + WORD_CYC) begin
                    t = cyc - m_pop[i] - 1;
                    b = t / (10 * B);
                    p = (t % (10 * B)) / B;
                    if (p == 0)      txe = 1'b0;
                    else if (p == 9) txe = 1'b1;
                    else             txe = m_val[i][8 * (3 - b) + p - 1];
                end
            end
            chk1("TxD", bus.TxD, txe);
            chk1("busy", bus.busy, (occ > 0) || act);
            chk1("fifo_full", bus.fifo_full, occ == D);
            chk1("overflow", bus.overflow, (ovf_at >= 0) && (cyc >= ovf_at));
        end
        if (bus.fifo_full === 1'b1) full_seen = 1'b1;
    end

    // Hub-side receiver: samples bit centres, shifts bytes in at the bottom, scores whole words.
    initial begin : monitor
        int          s, bc, ws, target;
        logic [7:0]  by;
        logic [31:0] w;
        logic        prev;
        bit          aborted;
        exp_t        e;
        prev = 1'b1;
        bc   = 0;
        ws   = 0;
        w    = '0;
        by   = '0;
        forever begin
            @(negedge clk);
            if (mon_abort || !chk_en) begin
                mon_abort = 1'b0;
                bc        = 0;
                prev      = 1'b1;
                continue;
            end
            if (prev === 1'b1 && bus.TxD === 1'b0) begin
                s       = cyc;
                aborted = 1'b0;
                for (int i = 0; i < 9 && !aborted; i++) begin
                    target = s + B * (1 + i) + B / 2;
                    while (cyc < target && !mon_abort) @(negedge clk);
                    if (mon_abort)  aborted = 1'b1;
                    else if (i < 8) by[i] = bus.TxD;
                    else            chk1("stop_bit", bus.TxD, 1'b1);
                end
                if (aborted) begin
                    mon_abort = 1'b0;
                    bc        = 0;
                    prev      = bus.TxD;
                    continue;
                end
                if (bc == 0) ws = s;
                w = {w[23:0], by};
                bc++;
                if (bc == 4) begin
                    bc = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word cycle %0d: got %0h expected none", cyc, w);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word", w, e.w);
                        chk("start_cycle", ws, e.st);
                    end
                end
            end
            prev = bus.TxD;
        end
    end

    initial begin : watchdog
        #(10 * 60000);
        $display("FAIL watchdog cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k, n, base, bpop;
        bus.nonce     = '0;
        bus.new_nonce = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();
        chk1("rst_txd", bus.TxD, 1'b1);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_full", bus.fifo_full, 1'b0);
        chk1("rst_ovf", bus.overflow, 1'b0);

        // Single word: busy spans 161 cycles starting at the push edge.
        @(negedge clk);
        strobe(32'hDEADBEEF);
        n = 0;
        while (bus.busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, 161);
        drain();

        // Sparse bit pattern for LSB-first ordering.
        strobe(32'h80010000);
        drain();

        // Burst of four: first pop frees a slot, so never full.
        full_seen = 1'b0;
        for (int i = 1; i <= 4; i++) strobe(i);
        drain();
        chk1("burst_full_seen", full_seen, 1'b0);
        chk1("burst_ovf", bus.overflow, 1'b0);

        // Six strobes: sixth is dropped, overflow sticks until reset.
        for (int i = 1; i <= 6; i++) strobe(i);
        chk1("ovf_after_6th", bus.overflow, 1'b1);
        drain();
        chk1("ovf_sticky", bus.overflow, 1'b1);
        do_reset();
        chk1("ovf_cleared", bus.overflow, 1'b0);

        // Push on the very edge the head of a full FIFO is popped.
        strobe(32'hA0A0A0A0);
        base = m_pop.size();
        strobe(32'hB1B1B1B1);
        strobe(32'hC2C2C2C2);
        strobe(32'hD3D3D3D3);
        strobe(32'hE4E4E4E4);
        bpop = m_pop[base];
        while (cyc + 1 < bpop) @(negedge clk);
        chk1("full_before_pop", bus.fifo_full, 1'b1);
        strobe(32'hF5F5F5F5);
        chk1("ovf_push_pop", bus.overflow, 1'b1);
        drain();
        do_reset();

        // Reset in the middle of byte 2, with another word still queued.
        strobe(32'hA5A5A5A5);
        k = cyc;
        strobe(32'h11111111);
        while (cyc < k + 2 + 2 * 10 * B + 5) @(negedge clk);
        do_reset();
        chk1("midrst_txd", bus.TxD, 1'b1);
        chk1("midrst_busy", bus.busy, 1'b0);
        chk1("midrst_full", bus.fifo_full, 1'b0);
        strobe(32'h12345678);
        drain();

        // Random traffic, including occasional bursts that overrun the FIFO.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                for (int j = 0; j < 6; j++) strobe($urandom);
            end else if ($urandom_range(0, 149) == 0) begin
                strobe($urandom);
            end else begin
                @(negedge clk);
            end
        end
        drain();
        chk("exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
